// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: symbol width, control tokens and
// word-alignment FSM states, common to all three colour channels.
package tmds_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] CTRL_00 = 10'h354;
   localparam logic [SYM_W-1:0] CTRL_01 = 10'h0AB;
   localparam logic [SYM_W-1:0] CTRL_10 = 10'h154;
   localparam logic [SYM_W-1:0] CTRL_11 = 10'h2AB;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SLIP   = 2'd1,
      SETTLE = 2'd2,
      LOCKED = 2'd3
   } state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Purely combinational decode of one 10-bit TMDS symbol into either a
// control pair or an 8-bit pixel byte.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [SYM_W-1:0] sym,
   output logic             is_ctrl,
   output logic [1:0]       ctrl,
   output logic [7:0]       data
);

   logic [7:0] d;

   // Bit 9 flags an inverted payload; bit 8 selects XOR vs XNOR chaining.
   assign d = sym[9] ? ~sym[7:0] : sym[7:0];

   always_comb begin
      is_ctrl = 1'b1;
      ctrl    = 2'b00;
      data    = 8'h00;
      case (sym)
         CTRL_00: ctrl = 2'b00;
         CTRL_01: ctrl = 2'b01;
         CTRL_10: ctrl = 2'b10;
         CTRL_11: ctrl = 2'b11;
         default: begin
            is_ctrl = 1'b0;
            data    = {d[7:1] ^ d[6:0] ^ {7{~sym[8]}}, d[0]};
         end
      endcase
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: two-stage symbol decode pipeline plus a word-alignment
// FSM that hunts for control-token runs and requests deserializer bitslips.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int CTRL_RUN_LOCK = 16,
   parameter int SLIP_TIMEOUT  = 4096,
   parameter int SLIP_SETTLE   = 8,
   parameter int LOSS_TIMEOUT  = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] tmds_i,
   output logic             bitslip_o,
   output logic             locked_o,
   output logic             de_o,
   output logic [1:0]       c_o,
   output logic [7:0]       data_o,
   output logic [3:0]       slip_cnt_o
);

   localparam int RUN_W    = $clog2(CTRL_RUN_LOCK) + 1;
   localparam int TMO_W    = $clog2(SLIP_TIMEOUT) + 1;
   localparam int SETTLE_W = $clog2(SLIP_SETTLE) + 1;
   localparam int LOSS_W   = $clog2(LOSS_TIMEOUT) + 1;

   localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(CTRL_RUN_LOCK - 1);
   localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(SLIP_TIMEOUT - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE - 1);
   localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_TIMEOUT - 1);

   logic [SYM_W-1:0]    sym_q;
   logic                is_ctrl;
   logic [1:0]          ctrl;
   logic [7:0]          dec_data;

   state_t              state_q, state_d;
   logic [RUN_W-1:0]    run_q, run_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [LOSS_W-1:0]   loss_q, loss_d;
   logic [3:0]          slip_q, slip_d;

   tmds_symbol_decode u_decode (
      .sym     (sym_q),
      .is_ctrl (is_ctrl),
      .ctrl    (ctrl),
      .data    (dec_data)
   );

   // Input and output registers give a fixed two-cycle latency; c_o keeps
   // the last control pair through data periods.
   always_ff @(posedge clk) begin
      if (rst) begin
         sym_q  <= '0;
         de_o   <= 1'b0;
         c_o    <= 2'b00;
         data_o <= 8'h00;
      end else begin
         sym_q  <= tmds_i;
         de_o   <= ~is_ctrl;
         data_o <= dec_data;
         if (is_ctrl) begin
            c_o <= ctrl;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SEARCH;
         run_q    <= '0;
         tmo_q    <= '0;
         settle_q <= '0;
         loss_q   <= '0;
         slip_q   <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         tmo_q    <= tmo_d;
         settle_q <= settle_d;
         loss_q   <= loss_d;
         slip_q   <= slip_d;
      end
   end

   // Lock is tested before the slip timeout so a simultaneous hit locks.
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      tmo_d    = tmo_q;
      settle_d = settle_q;
      loss_d   = loss_q;
      slip_d   = slip_q;
      case (state_q)
         SEARCH: begin
            run_d = is_ctrl ? run_q + 1'b1 : '0;
            tmo_d = tmo_q + 1'b1;
            if (is_ctrl && run_q == RUN_LAST) begin
               state_d = LOCKED;
               slip_d  = '0;
               loss_d  = '0;
               run_d   = '0;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = SLIP;
               run_d   = '0;
               tmo_d   = '0;
            end
         end
         SLIP: begin
            slip_d   = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
            settle_d = '0;
            state_d  = SETTLE;
         end
         SETTLE: begin
            run_d    = '0;
            tmo_d    = '0;
            settle_d = settle_q + 1'b1;
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = SEARCH;
            end
         end
         LOCKED: begin
            loss_d = is_ctrl ? '0 : loss_q + 1'b1;
            if (!is_ctrl && loss_q == LOSS_LAST) begin
               state_d = SEARCH;
               loss_d  = '0;
               run_d   = '0;
               tmo_d   = '0;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   assign bitslip_o  = (state_q == SLIP);
   assign locked_o   = (state_q == LOCKED);
   assign slip_cnt_o = slip_q;

endmodule
